// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    localparam logic [6:0]  PC_HALT_OP    = 7'b1111111;
    localparam int unsigned PC_RESET_ADDR = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and the occupancy count saturates at DEPTH.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] head_q;     // next slot to write
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] head_next;
    logic [IDX_W-1:0] head_prev;

    assign head_next = (head_q == IDX_W'(DEPTH - 1)) ? '0 : head_q + IDX_W'(1);
    assign head_prev = (head_q == '0) ? IDX_W'(DEPTH - 1) : head_q - IDX_W'(1);

    assign top   = mem[head_prev];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            count_q <= '0;
        end else if (push && !pop) begin
            head_q <= head_next;
            if (!full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop && !push && !empty) begin
            head_q  <= head_prev;
            count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[head_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: step/redirect/stall/halt with a one-cycle bubble
// after redirect or resume. Optional return-address stack under `PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               STEP       = 1,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR),
    parameter int               OP_W       = 7,
    parameter logic [OP_W-1:0]  HALT_OP    = OP_W'(PC_HALT_OP),
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [OP_W-1:0]  opcode,
    input  logic             op_valid,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_addr,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             halted,
    input  logic             call,
    input  logic             ret,
    output logic             ras_empty,
    output pc_state_e        state_dbg
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             halted_q, halted_d;

    logic [WIDTH-1:0] pc_inc;
    logic             halt_req;
    logic             ret_take;
    logic             call_take;
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;

    assign pc_inc   = pc_q + STEP_W;
    assign halt_req = op_valid && (opcode == HALT_OP);

`ifdef PC_RAS_EN
    logic ras_empty_w;
    logic ras_full_unused;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full_unused),
        .empty     (ras_empty_w)
    );

    // A ret on an empty stack is dropped so the PC just increments.
    assign ret_take  = ret && !ras_empty_w;
    assign call_take = call && !ret;
    assign ras_empty = ras_empty_w;
`else
    logic unused_ras;

    assign unused_ras = call | ret | ras_push | ras_pop | (RAS_DEPTH == 0);
    assign ret_take   = 1'b0;
    assign call_take  = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_ADDR;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
        end
    end

    // RUN priority: redirect > ret > halt > stall > call/increment.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        halted_d   = halted_q;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redir_valid) begin
                    pc_d       = redir_addr;
                    pc_valid_d = 1'b0;
                    state_d    = ST_BUBBLE;
                end else if (ret_take) begin
                    pc_d       = ras_top;
                    ras_pop    = 1'b1;
                    pc_valid_d = 1'b0;
                    state_d    = ST_BUBBLE;
                end else if (halt_req) begin
                    halted_d   = 1'b1;
                    pc_valid_d = 1'b0;
                    state_d    = ST_HALTED;
                end else if (!stall) begin
                    pc_d     = pc_inc;
                    ras_push = call_take;
                end
            end
            ST_BUBBLE: begin
                if (redir_valid) begin
                    pc_d = redir_addr;
                end else begin
                    pc_valid_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    halted_d = 1'b0;
                    state_d  = ST_BUBBLE;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign halted    = halted_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed checks of pc_sequencer (32-bit, STEP=1) plus an 8-bit STEP=4 wrap instance.
module tb_pc_sequencer;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [6:0]  opcode;
    logic        op_valid;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        resume;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic        pc_valid;
    logic        halted;
    logic        ras_empty;
    pc_state_e   state_dbg;

    logic        w_stall = 1'b0;
    logic [6:0]  w_opcode = 7'h00;
    logic        w_op_valid = 1'b0;
    logic        w_redir_valid = 1'b0;
    logic [7:0]  w_redir_addr = 8'h00;
    logic        w_resume = 1'b0;
    logic        w_call = 1'b0;
    logic        w_ret = 1'b0;
    logic [7:0]  pc8;
    logic        pc_valid8;
    logic        halted8;
    logic        ras_empty8;
    pc_state_e   state8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH      (32),
        .STEP       (1),
        .RESET_ADDR (32'h0),
        .OP_W       (7),
        .HALT_OP    (7'h7F),
        .RAS_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .opcode      (opcode),
        .op_valid    (op_valid),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .resume      (resume),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .halted      (halted),
        .call        (call),
        .ret         (ret),
        .ras_empty   (ras_empty),
        .state_dbg   (state_dbg)
    );

    pc_sequencer #(
        .WIDTH      (8),
        .STEP       (4),
        .RESET_ADDR (8'hF8),
        .OP_W       (7),
        .HALT_OP    (7'h7F),
        .RAS_DEPTH  (2)
    ) dut8 (
        .clk         (clk),
        .rst         (rst),
        .stall       (w_stall),
        .opcode      (w_opcode),
        .op_valid    (w_op_valid),
        .redir_valid (w_redir_valid),
        .redir_addr  (w_redir_addr),
        .resume      (w_resume),
        .pc          (pc8),
        .pc_valid    (pc_valid8),
        .halted      (halted8),
        .call        (w_call),
        .ret         (w_ret),
        .ras_empty   (ras_empty8),
        .state_dbg   (state8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] p, input logic v, input logic h);
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".valid"}, 32'(pc_valid), 32'(v));
        chk({tag, ".halted"}, 32'(halted), 32'(h));
    endtask

    task automatic chk_state(input string tag, input pc_state_e s);
        chk({tag, ".state"}, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        // Reset wins over a simultaneous redirect and halt opcode.
        rst = 1'b0; stall = 1'b0; opcode = 7'h7F; op_valid = 1'b1;
        redir_valid = 1'b1; redir_addr = 32'h77; resume = 1'b0; call = 1'b0; ret = 1'b0;
        step();
        step();
        chk_pc("reset", 32'h0, 1'b1, 1'b0);
        chk_state("reset", ST_RUN);
        chk("reset.ras_empty", 32'(ras_empty), 32'h1);
        chk("reset.pc8", 32'(pc8), 32'hF8);

        opcode = 7'h00; op_valid = 1'b0; redir_valid = 1'b0;
        rst = 1'b1;
        step(); chk_pc("run1", 32'h1, 1'b1, 1'b0); chk("wrap.pc8_fc", 32'(pc8), 32'hFC);
        step(); chk_pc("run2", 32'h2, 1'b1, 1'b0); chk("wrap.pc8_00", 32'(pc8), 32'h00);
        step(); chk_pc("run3", 32'h3, 1'b1, 1'b0); chk("wrap.pc8_04", 32'(pc8), 32'h04);
        step(); chk_pc("run4", 32'h4, 1'b1, 1'b0);

        redir_valid = 1'b1; redir_addr = 32'h40;
        step(); chk_pc("redir_bubble", 32'h40, 1'b0, 1'b0); chk_state("redir_bubble", ST_BUBBLE);
        redir_valid = 1'b0;
        step(); chk_pc("redir_live", 32'h40, 1'b1, 1'b0); chk_state("redir_live", ST_RUN);
        step(); chk_pc("redir_next", 32'h41, 1'b1, 1'b0);

        // Second redirect while still in the bubble.
        redir_valid = 1'b1; redir_addr = 32'h80;
        step(); chk_pc("bub_redir1", 32'h80, 1'b0, 1'b0);
        redir_addr = 32'h90;
        step(); chk_pc("bub_redir2", 32'h90, 1'b0, 1'b0); chk_state("bub_redir2", ST_BUBBLE);
        redir_valid = 1'b0;
        step(); chk_pc("bub_live", 32'h90, 1'b1, 1'b0);
        step(); chk_pc("bub_next", 32'h91, 1'b1, 1'b0);

        op_valid = 1'b1; opcode = 7'h7F;
        step(); chk_pc("halt_enter", 32'h91, 1'b0, 1'b1); chk_state("halt_enter", ST_HALTED);
        for (int i = 0; i < 10; i++) begin
            redir_valid = i[0];
            redir_addr  = 32'h55;
            stall       = ~i[0];
            step();
            chk_pc("halt_hold", 32'h91, 1'b0, 1'b1);
        end
        op_valid = 1'b0; redir_valid = 1'b0; stall = 1'b0;
        resume = 1'b1;
        step(); chk_pc("resume_bubble", 32'h91, 1'b0, 1'b0); chk_state("resume_bubble", ST_BUBBLE);
        resume = 1'b0;
        step(); chk_pc("resume_live", 32'h91, 1'b1, 1'b0);
        step(); chk_pc("resume_next", 32'h92, 1'b1, 1'b0);

        // Non-halt opcode, and halt opcode without op_valid, both just advance.
        op_valid = 1'b1; opcode = 7'h13;
        step(); chk_pc("other_op", 32'h93, 1'b1, 1'b0);
        op_valid = 1'b0; opcode = 7'h7F;
        step(); chk_pc("halt_not_valid", 32'h94, 1'b1, 1'b0);
        opcode = 7'h00;

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pc("stall_hold", 32'h94, 1'b1, 1'b0);
        end
        redir_valid = 1'b1; redir_addr = 32'h200;
        step(); chk_pc("stall_redir", 32'h200, 1'b0, 1'b0);
        stall = 1'b0; redir_valid = 1'b0;
        step(); chk_pc("stall_redir_live", 32'h200, 1'b1, 1'b0);

        // Redirect beats a halt opcode in the same cycle.
        redir_valid = 1'b1; redir_addr = 32'h300; op_valid = 1'b1; opcode = 7'h7F;
        step(); chk_pc("redir_vs_halt", 32'h300, 1'b0, 1'b0); chk_state("redir_vs_halt", ST_BUBBLE);
        redir_valid = 1'b0; op_valid = 1'b0;
        step(); chk_pc("redir_vs_halt_live", 32'h300, 1'b1, 1'b0);
        step(); chk_pc("redir_vs_halt_next", 32'h301, 1'b1, 1'b0);

        // Halt takes priority over stall.
        stall = 1'b1; op_valid = 1'b1;
        step(); chk_pc("halt_vs_stall", 32'h301, 1'b0, 1'b1);
        stall = 1'b0; op_valid = 1'b0; resume = 1'b1;
        step(); chk_pc("resume2", 32'h301, 1'b0, 1'b0);
        resume = 1'b0;
        step(); chk_pc("resume2_live", 32'h301, 1'b1, 1'b0);

`ifdef PC_RAS_EN
        // Three calls into a 2-deep stack: 0x11 is overwritten, leaving 0x21, 0x31.
        for (int k = 1; k <= 3; k++) begin
            redir_valid = 1'b1; redir_addr = 32'(k * 16);
            step();
            redir_valid = 1'b0;
            step(); chk_pc("ras_target", 32'(k * 16), 1'b1, 1'b0);
            call = 1'b1;
            step(); chk_pc("ras_call", 32'(k * 16 + 1), 1'b1, 1'b0);
            call = 1'b0;
            chk("ras_call.empty", 32'(ras_empty), 32'h0);
        end
        ret = 1'b1;
        step(); chk_pc("ret1", 32'h31, 1'b0, 1'b0); chk_state("ret1", ST_BUBBLE);
        ret = 1'b0;
        step(); chk_pc("ret1_live", 32'h31, 1'b1, 1'b0);
        ret = 1'b1;
        step(); chk_pc("ret2", 32'h21, 1'b0, 1'b0);
        ret = 1'b0;
        step(); chk_pc("ret2_live", 32'h21, 1'b1, 1'b0);
        chk("ret2.empty", 32'(ras_empty), 32'h1);
        ret = 1'b1;
        step(); chk_pc("ret3_ignored", 32'h22, 1'b1, 1'b0);
        ret = 1'b0;
        chk("ret3.empty", 32'(ras_empty), 32'h1);
`else
        call = 1'b1;
        step(); chk_pc("call_ignored", 32'h302, 1'b1, 1'b0);
        call = 1'b0; ret = 1'b1;
        step(); chk_pc("ret_ignored", 32'h303, 1'b1, 1'b0);
        ret = 1'b0;
        chk("no_ras.empty", 32'(ras_empty), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the multi-cycle pipelined RISC-V core. Sits at the head of the fetch stage.
- Generates the instruction address each cycle:
  - sequential increment by a programmable step
  - redirect (branch/jump) override
  - pipeline stall hold
  - opcode-triggered halt with explicit resume
- Adds a valid flag and a one-cycle bubble after redirect/resume so fetch can discard stale instructions.

Parameters:
- WIDTH, 32, address width in bits
- STEP, 1, increment per sequential advance (1 = word-indexed instruction memory, 4 = byte-addressed)
- RESET_ADDR, 0, PC value loaded on reset
- OP_W, 7, width of the decoded opcode input
- HALT_OP, 7'b1111111, opcode value that requests halt
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset
- stall  input  1  hold PC, no advance
- opcode  input  OP_W  opcode of instruction currently in decode
- op_valid  input  1  opcode is valid this cycle
- redir_valid  input  1  load redir_addr as next PC
- redir_addr  input  WIDTH  branch/jump target
- resume  input  1  leave HALTED state
- pc  output  WIDTH  current instruction address
- pc_valid  output  1  pc is a live fetch address; 0 = bubble
- halted  output  1  sequencer in HALTED state
- call  input  1  push pc+STEP on RAS (PC_RAS_EN only)
- ret  input  1  pop RAS into PC (PC_RAS_EN only)
- ras_empty  output  1  RAS has no entries (PC_RAS_EN only)

Behaviour:
- Reset (rst==0 at posedge), regardless of any other input:
  - pc=RESET_ADDR, pc_valid=1, halted=0, FSM=RUN
  - RAS pointer=0, ras_empty=1
- FSM states: RUN, BUBBLE, HALTED.
- RUN: per-cycle priority, first match wins:
  1. redir_valid: pc<=redir_addr, pc_valid<=0, goto BUBBLE.
  2. op_valid && opcode==HALT_OP: pc holds, halted<=1, pc_valid<=0, goto HALTED.
  3. stall: pc, pc_valid hold.
  4. Otherwise: pc<=pc+STEP.
- BUBBLE: lasts exactly one cycle, then pc_valid<=1 and goto RUN.
  - pc does not advance in BUBBLE, so redir_addr is fetched valid on the next cycle.
  - A redir_valid arriving in BUBBLE replaces pc and stays in BUBBLE one more cycle.
- HALTED: pc holds; redirect, stall and opcode are ignored.
  - resume: halted<=0, goto BUBBLE (pc unchanged; same address re-fetched valid).
- Arithmetic: pc+STEP is computed modulo 2^WIDTH; at 2^WIDTH-STEP the PC wraps to 0 with no flag.
- Redirect and halt in the same cycle: redirect wins and the halt opcode is dropped, since it belongs to a squashed path.
- Latency: every update is visible on pc one cycle after the triggering inputs. No combinational path from any input to pc.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: a RAS_DEPTH-entry return-address stack.
  - call in RUN (not stalled) pushes pc+STEP.
  - ret in RUN sets pc<=top and pops, pc_valid<=0, goto BUBBLE.
  - Priority: redir_valid > ret > halt > stall > call/increment.
  - Push when full overwrites the oldest entry (circular), pointer saturates at depth.
  - Pop when empty is ignored; PC increments normally.
  - Simultaneous call+ret: ret only.
- Undefined: call/ret are ignored, ras_empty is tied to 1, no RAS storage is generated.

Decomposition:
- Shared package pc_pkg:
  - FSM state enum (RUN, BUBBLE, HALTED)
  - HALT_OP default constant
  - reset-address constant
- One sub-module: pc_ras (circular stack; push/pop/full/empty), instantiated only under PC_RAS_EN.

Test Plan:
- Reset then 5 free-run cycles, STEP=1 -> pc 0,1,2,3,4; pc_valid=1 throughout.
- redir_valid with redir_addr=0x40 at pc=3 -> next pc=0x40, pc_valid=0 for one cycle, then pc=0x40 valid, then 0x41.
- op_valid with opcode=7'h7F at pc=6 -> halted=1, pc stays 6 for 10 cycles despite redirects; resume -> bubble, then pc=6 valid, then 7.
- stall held 3 cycles at pc=9 -> pc=9 throughout; stall+redir_valid same cycle -> redirect taken.
- WIDTH=8, STEP=4, pc=0xFC -> next pc=0x00.
- With PC_RAS_EN, RAS_DEPTH=2:
  - call at pc=0x10, 0x20, 0x30 (third push overwrites the oldest entry).
  - ret x2 -> pc 0x31 then 0x21.
  - Third ret -> ignored, ras_empty=1.
